// File: rtl/tblink_rpc_invoke_responder.sv
// rtl/tblink_rpc_invoke_responder.sv - TbLink invoke responder: header/param intake, BFM dispatch, timed response
module tblink_rpc_invoke_responder #(
  parameter int CALL_ID_W   = 16,
  parameter int METHOD_W    = 8,
  parameter int DATA_W      = 32,
  parameter int MAX_PARAMS  = 4,
  parameter int NUM_METHODS = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         hdr_valid,
  output logic                         hdr_ready,
  input  logic [CALL_ID_W-1:0]         hdr_call_id,
  input  logic [METHOD_W-1:0]          hdr_method,
  input  logic [7:0]                   hdr_nparams,
  input  logic                         prm_valid,
  output logic                         prm_ready,
  input  logic [DATA_W-1:0]            prm_data,
  output logic                         bfm_valid,
  input  logic                         bfm_ready,
  output logic [METHOD_W-1:0]          bfm_method,
  output logic [MAX_PARAMS*DATA_W-1:0] bfm_params,
  output logic [7:0]                   bfm_nparams,
  input  logic                         bfm_done,
  input  logic [DATA_W-1:0]            bfm_rval,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [CALL_ID_W-1:0]         rsp_call_id,
  output logic [DATA_W-1:0]            rsp_rval,
  output logic [1:0]                   rsp_status,
  output logic                         busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_BAD_METHOD = 2'd1;
  localparam logic [1:0] ST_BAD_ARGS   = 2'd2;
  localparam logic [1:0] ST_TIMEOUT    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAMS,
    S_DISPATCH,
    S_WAIT,
    S_RSP
  } state_t;

  state_t                         state, state_d;
  logic [CALL_ID_W-1:0]           call_id_q;
  logic [METHOD_W-1:0]            method_q;
  logic [7:0]                     nparams_q;
  logic [7:0]                     prm_idx;
  logic [MAX_PARAMS*DATA_W-1:0]   params_q;
  logic [1:0]                     status_q;
  logic [DATA_W-1:0]              rval_q;
  logic [TMO_W-1:0]               tmo_cnt;

  logic hdr_bad_method;
  logic hdr_bad_args;
  logic last_beat;
  logic tmo_expire;

  assign hdr_bad_method = int'(hdr_method) >= NUM_METHODS;
  assign hdr_bad_args   = int'(hdr_nparams) > MAX_PARAMS;
  assign last_beat      = (prm_idx + 8'd1) == nparams_q;
  // Counter value 1 means this WAIT cycle is the last one before expiry.
  assign tmo_expire     = tmo_cnt <= TMO_W'(1);

  always_comb begin
    state_d   = state;
    hdr_ready = 1'b0;
    prm_ready = 1'b0;
    bfm_valid = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        hdr_ready = 1'b1;
        if (hdr_valid) begin
          if (hdr_nparams != 8'd0)  state_d = S_PARAMS;
          else if (hdr_bad_method)  state_d = S_RSP;
          else                      state_d = S_DISPATCH;
        end
      end
      S_PARAMS: begin
        prm_ready = 1'b1;
        if (prm_valid && last_beat)
          state_d = (status_q == ST_OK) ? S_DISPATCH : S_RSP;
      end
      S_DISPATCH: begin
        bfm_valid = 1'b1;
        if (bfm_ready)
          state_d = bfm_done ? S_RSP : S_WAIT;
      end
      S_WAIT: begin
        if (bfm_done || tmo_expire)
          state_d = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      call_id_q <= '0;
      method_q  <= '0;
      nparams_q <= '0;
      prm_idx   <= '0;
      params_q  <= '0;
      status_q  <= ST_OK;
      rval_q    <= '0;
      tmo_cnt   <= '0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (hdr_valid) begin
            call_id_q <= hdr_call_id;
            method_q  <= hdr_method;
            nparams_q <= hdr_nparams;
            prm_idx   <= '0;
            params_q  <= '0;
            rval_q    <= '0;
            if (hdr_bad_method)    status_q <= ST_BAD_METHOD;
            else if (hdr_bad_args) status_q <= ST_BAD_ARGS;
            else                   status_q <= ST_OK;
          end
        end
        S_PARAMS: begin
          if (prm_valid) begin
            for (int i = 0; i < MAX_PARAMS; i++) begin
              if (int'(prm_idx) == i)
                params_q[i*DATA_W +: DATA_W] <= prm_data;
            end
            if (prm_idx != 8'hFF)
              prm_idx <= prm_idx + 8'd1;
          end
        end
        S_DISPATCH: begin
          if (bfm_ready) begin
            tmo_cnt <= TMO_W'(TIMEOUT);
            if (bfm_done)
              rval_q <= bfm_rval;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt - TMO_W'(1);
          if (bfm_done) begin
            rval_q   <= bfm_rval;
            status_q <= ST_OK;
          end else if (tmo_expire) begin
            rval_q   <= '0;
            status_q <= ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bfm_method  = method_q;
  assign bfm_params  = params_q;
  assign bfm_nparams = nparams_q;
  assign rsp_call_id = call_id_q;
  assign rsp_rval    = rval_q;
  assign rsp_status  = status_q;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_tblink_rpc_invoke_responder.sv
// tb/tb_tblink_rpc_invoke_responder.sv - randomized self-checking bench for tblink_rpc_invoke_responder
module tb_tblink_rpc_invoke_responder;

  localparam int TMO = 16;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         hdr_valid = 1'b0;
  logic         hdr_ready;
  logic [15:0]  hdr_call_id = '0;
  logic [7:0]   hdr_method = '0;
  logic [7:0]   hdr_nparams = '0;
  logic         prm_valid = 1'b0;
  logic         prm_ready;
  logic [31:0]  prm_data = '0;
  logic         bfm_valid;
  logic         bfm_ready = 1'b0;
  logic [7:0]   bfm_method;
  logic [127:0] bfm_params;
  logic [7:0]   bfm_nparams;
  logic         bfm_done = 1'b0;
  logic [31:0]  bfm_rval = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [15:0]  rsp_call_id;
  logic [31:0]  rsp_rval;
  logic [1:0]   rsp_status;
  logic         busy;

  tblink_rpc_invoke_responder #(
    .CALL_ID_W(16), .METHOD_W(8), .DATA_W(32), .MAX_PARAMS(4),
    .NUM_METHODS(8), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_call_id(hdr_call_id),
    .hdr_method(hdr_method), .hdr_nparams(hdr_nparams),
    .prm_valid(prm_valid), .prm_ready(prm_ready), .prm_data(prm_data),
    .bfm_valid(bfm_valid), .bfm_ready(bfm_ready), .bfm_method(bfm_method),
    .bfm_params(bfm_params), .bfm_nparams(bfm_nparams),
    .bfm_done(bfm_done), .bfm_rval(bfm_rval),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_call_id(rsp_call_id),
    .rsp_rval(rsp_rval), .rsp_status(rsp_status), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Transaction-level expectations for the call in flight
  logic [15:0]  exp_call_id = '0;
  logic [7:0]   exp_method = '0;
  logic [7:0]   exp_n = '0;
  logic [127:0] exp_params = '0;
  logic [1:0]   exp_status = '0;
  logic [31:0]  exp_rval = '0;
  logic         exp_dispatch = 1'b0;
  logic [31:0]  prm_buf [8];

  logic [127:0] got_params;
  logic [15:0]  got_call_id;
  logic [31:0]  got_rval;
  logic [1:0]   got_status;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_hdr_ready", hdr_ready, 1);
      chk("rst_valids", {bfm_valid, rsp_valid, prm_ready, busy}, 0);
      chk("rst_fields", {rsp_call_id, rsp_rval, rsp_status, bfm_method, bfm_nparams}, 0);
      chk("rst_params", bfm_params, 0);
    end else begin
      chk("busy_vs_hdr_ready", busy, !hdr_ready);
      if (bfm_valid) begin
        chk("bfm_valid_allowed", exp_dispatch, 1);
        chk("bfm_method", bfm_method, exp_method);
        chk("bfm_nparams", bfm_nparams, exp_n);
        chk("bfm_params", bfm_params, exp_params);
      end
      if (rsp_valid) begin
        chk("rsp_call_id", rsp_call_id, exp_call_id);
        chk("rsp_status", rsp_status, exp_status);
        chk("rsp_rval", rsp_rval, exp_rval);
        chk("rsp_no_hdr_overlap", hdr_ready, 0);
      end
    end
  end

  // Waits up to 200 negedges for the selected DUT output; cnt=1 means seen at the first one.
  task automatic wait_sig(input int which, input string name, output int cnt);
    logic s;
    cnt = 0;
    forever begin
      @(negedge clock);
      cnt++;
      case (which)
        0: s = hdr_ready;
        1: s = prm_ready;
        2: s = bfm_valid;
        default: s = rsp_valid;
      endcase
      if (s) return;
      if (cnt >= 200) begin
        chk({"wait_", name}, 0, 1);
        return;
      end
    end
  endtask

  task automatic set_model(input logic [15:0] id, input logic [7:0] m, input logic [7:0] n,
                           input int ddly, input logic [31:0] rv);
    if (m >= 8)                      exp_status = 2'd1;
    else if (n > 4)                  exp_status = 2'd2;
    else if (ddly < 0 || ddly > TMO) exp_status = 2'd3;
    else                             exp_status = 2'd0;
    exp_call_id  = id;
    exp_method   = m;
    exp_n        = n;
    exp_rval     = (exp_status == 2'd0) ? rv : 32'd0;
    exp_dispatch = (exp_status == 2'd0) || (exp_status == 2'd3);
    exp_params   = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(n)) exp_params[i*32 +: 32] = prm_buf[i];
  endtask

  task automatic send_hdr(input logic [15:0] id, input logic [7:0] m, input logic [7:0] n);
    int c;
    hdr_valid = 1'b1; hdr_call_id = id; hdr_method = m; hdr_nparams = n;
    wait_sig(0, "hdr", c);
    chk("hdr_ready_at_once", c, 1);
    @(posedge clock); #1;
    hdr_valid = 1'b0;
  endtask

  // Starts and ends at posedge+1. ddly: cycles after the dispatch handshake that bfm_done pulses (-1 never).
  task automatic run_call(input logic [15:0] id, input logic [7:0] m, input logic [7:0] n,
                          input int rdly, input int ddly, input logic [31:0] rv, input int hold);
    int c;
    set_model(id, m, n, ddly, rv);
    send_hdr(id, m, n);
    for (int k = 0; k < int'(n); k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
      end
      prm_valid = 1'b1; prm_data = prm_buf[k];
      wait_sig(1, "prm", c);
      @(posedge clock); #1;
      prm_valid = 1'b0;
    end
    if (exp_dispatch) begin
      wait_sig(2, "bfm_valid", c);
      chk("dispatch_latency", c, 1);
      got_params = bfm_params;
      repeat (rdly) @(negedge clock);
      bfm_ready = 1'b1;
      bfm_done  = (ddly == 0);
      bfm_rval  = (ddly == 0) ? rv : $urandom;
      @(posedge clock); #1;
      bfm_ready = 1'b0; bfm_done = 1'b0; bfm_rval = $urandom;
      if (exp_status == 2'd0 && ddly > 0) begin
        repeat (ddly - 1) begin
          @(posedge clock); #1;
        end
        bfm_done = 1'b1; bfm_rval = rv;
        @(posedge clock); #1;
        bfm_done = 1'b0; bfm_rval = $urandom;
      end
    end else begin
      got_params = '0;
    end
    wait_sig(3, "rsp_valid", c);
    chk("rsp_latency", c, (exp_status == 2'd3) ? TMO + 1 : 1);
    got_call_id = rsp_call_id; got_rval = rsp_rval; got_status = rsp_status;
    for (int h = 0; h < hold; h++) begin
      bfm_done = (h == 0);
      @(negedge clock);
    end
    bfm_done = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    @(negedge clock);
    chk("idle_after_rsp", {hdr_ready, busy, rsp_valid}, 3'b100);
    @(posedge clock); #1;
  endtask

  initial begin
    int m, n, r, ddly;
    #12;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Basic call with literal expectations
    prm_buf[0] = 32'h11; prm_buf[1] = 32'h22;
    run_call(16'h0005, 8'd2, 8'd2, 0, 3, 32'hABCD, 0);
    chk("t1_params", got_params, {32'h0, 32'h0, 32'h22, 32'h11});
    chk("t1_rsp", {got_call_id, got_rval, got_status}, {16'h0005, 32'hABCD, 2'd0});

    // Bad method consumes its beat, never dispatches
    prm_buf[0] = 32'h77;
    run_call(16'h0006, 8'd9, 8'd1, 0, 2, 32'h1234, 1);
    chk("t2_rsp", {got_rval, got_status}, {32'h0, 2'd1});

    // Too many params
    for (int i = 0; i < 6; i++) prm_buf[i] = i + 1;
    run_call(16'h0007, 8'd1, 8'd6, 0, 2, 32'h1234, 0);
    chk("t3_rsp", {got_rval, got_status}, {32'h0, 2'd2});

    // Timeout, late done ignored, then a normal call
    run_call(16'h0008, 8'd1, 8'd0, 1, -1, 32'h5555, 3);
    chk("t4_rsp", {got_rval, got_status}, {32'h0, 2'd3});
    bfm_done = 1'b1; bfm_rval = 32'hDEAD;
    @(posedge clock); #1;
    bfm_done = 1'b0;
    chk("late_done_ignored", {hdr_ready, busy}, 2'b10);
    prm_buf[0] = 32'hCAFE;
    run_call(16'h0009, 8'd7, 8'd1, 0, 1, 32'hBEEF, 0);
    chk("t4b_rsp", {got_call_id, got_rval, got_status}, {16'h0009, 32'hBEEF, 2'd0});

    // Long response backpressure, zero-latency BFM
    run_call(16'h000A, 8'd0, 8'd0, 2, 0, 32'h0F0F, 10);
    chk("t5_rsp", {got_rval, got_status}, {32'h0F0F, 2'd0});

    // Reset in WAIT
    set_model(16'h000B, 8'd3, 8'd0, -1, 32'h0);
    send_hdr(16'h000B, 8'd3, 8'd0);
    wait_sig(2, "bfm_valid_rst", r);
    bfm_ready = 1'b1;
    @(posedge clock); #1;
    bfm_ready = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk("rst_wait_async", {bfm_valid, rsp_valid, busy, hdr_ready}, 4'b0001);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Reset while dispatching drops bfm_valid at once
    send_hdr(16'h000C, 8'd3, 8'd0);
    wait_sig(2, "bfm_valid_rst2", r);
    #1 reset_n = 1'b0;
    #1 chk("rst_dispatch_async", {bfm_valid, hdr_ready}, 2'b01);
    @(posedge clock); #1;
    reset_n = 1'b1;
    prm_buf[0] = 32'h1; prm_buf[1] = 32'h2; prm_buf[2] = 32'h3; prm_buf[3] = 32'h4;
    run_call(16'h000D, 8'd4, 8'd4, 0, 2, 32'h4444, 0);
    chk("t6_rsp", {got_call_id, got_rval, got_status}, {16'h000D, 32'h4444, 2'd0});

    // Randomized calls
    for (int t = 0; t < 30; t++) begin
      m = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 9) : $urandom_range(0, 7);
      n = $urandom_range(0, 6);
      r = $urandom_range(0, 9);
      ddly = (r == 0) ? -1 : (r == 1) ? TMO : (r == 2) ? TMO + 1 : $urandom_range(0, 5);
      for (int i = 0; i < 8; i++) prm_buf[i] = $urandom;
      run_call(16'($urandom), 8'(m), 8'(n), $urandom_range(0, 3), ddly, $urandom,
               $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tblink_rpc_invoke_responder.md
Name: tblink_rpc_invoke_responder

Overview:
Hardware-side responder for TbLink invoke requests. It accepts an invoke header (call_id, method, param count), then a stream of parameter beats. It dispatches the call to a local BFM method port, waits for completion or a timeout, and returns a response tagged with the original call_id and a status code. It sits between the endpoint-facing request/response channels and synthesizable BFM logic. It handles one call at a time.

Parameters:
CALL_ID_W, 16, width of call identifier
METHOD_W, 8, width of method index
DATA_W, 32, width of each parameter and of the return value
MAX_PARAMS, 4, maximum parameters stored and dispatched
NUM_METHODS, 8, number of valid method indices (0..NUM_METHODS-1)
TIMEOUT, 1024, cycles to wait for bfm_done before aborting (must be >=1)

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
hdr_valid  in  1  invoke header valid
hdr_ready  out  1  header accepted when hdr_valid&&hdr_ready
hdr_call_id  in  CALL_ID_W  call identifier
hdr_method  in  METHOD_W  method index
hdr_nparams  in  8  number of parameter beats that follow
prm_valid  in  1  parameter beat valid
prm_ready  out  1  parameter beat accepted
prm_data  in  DATA_W  parameter value
bfm_valid  out  1  dispatch request to BFM
bfm_ready  in  1  BFM accepts dispatch
bfm_method  out  METHOD_W  dispatched method index
bfm_params  out  MAX_PARAMS*DATA_W  packed params; param i at [i*DATA_W +: DATA_W]
bfm_nparams  out  8  dispatched parameter count
bfm_done  in  1  one-cycle completion pulse from BFM
bfm_rval  in  DATA_W  return value, sampled with bfm_done
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_call_id  out  CALL_ID_W  echoed call_id
rsp_rval  out  DATA_W  return value (0 unless status OK)
rsp_status  out  2  0 OK, 1 BAD_METHOD, 2 BAD_ARGS, 3 TIMEOUT
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clock and reset_n.
- Reset: FSM goes to IDLE. All outputs are 0 except hdr_ready=1. Stored params, counters and call_id are cleared.
- The FSM has five states: IDLE, PARAMS, DISPATCH, WAIT, RSP.
- IDLE: hdr_ready=1, prm_ready=0. On a header handshake, latch call_id, method and nparams, and clear the param index.
  - If nparams=0: go to DISPATCH, or to RSP if the method is bad.
  - Otherwise: go to PARAMS.
  - Status is decided at the header: method>=NUM_METHODS gives BAD_METHOD. Otherwise nparams>MAX_PARAMS gives BAD_ARGS. BAD_METHOD has priority.
- PARAMS: hdr_ready=0, prm_ready=1. Every beat is accepted.
  - Beat k (0-based) is stored at slot k only if k<MAX_PARAMS; excess beats are consumed and discarded.
  - After the beat with k=nparams-1: go to DISPATCH if status is OK, else to RSP.
- DISPATCH: bfm_valid=1, with bfm_method, bfm_params and bfm_nparams held stable until bfm_ready.
  - Unused param slots read as 0.
  - On bfm_valid&&bfm_ready: go to WAIT and load the timeout counter with TIMEOUT.
  - If bfm_done is also high in that same cycle, capture rval and go directly to RSP with OK (zero-latency BFM).
- WAIT: the counter decrements each cycle.
  - On bfm_done: capture bfm_rval, status OK, go to RSP.
  - If the counter reaches 0 without bfm_done: status TIMEOUT, rval=0, go to RSP.
  - If bfm_done arrives on the same cycle the counter hits 0, bfm_done wins (OK).
- RSP: rsp_valid=1 with fields stable until rsp_ready.
  - On handshake: go to IDLE. hdr_ready rises the next cycle; there is no header/response overlap.
- A bfm_done outside WAIT (and outside the DISPATCH handshake cycle) is ignored, including a late done after a TIMEOUT.
- Latency, header to dispatch, with no stalls:
  - nparams=0: bfm_valid is asserted 1 cycle after the header handshake.
  - nparams=N: bfm_valid is asserted 1 cycle after the last param beat.
- Reset asserted mid-operation: immediate return to IDLE. Any pending response is lost, and bfm_valid/rsp_valid drop asynchronously.
- Counters: the param index saturates at 255 and does not wrap. The timeout counter uses $clog2(TIMEOUT+1) bits.

Test Plan:
- Reset, then header call_id=0x0005, method=2, nparams=2, params 0x11 and 0x22; BFM ready at once, done 3 cycles later with rval=0xABCD -> bfm_params slot0=0x11, slot1=0x22, others 0. Response call_id=5, rval=0xABCD, status 0.
- method=9 (NUM_METHODS=8), nparams=1 -> the beat is consumed, bfm_valid never asserts, response status=1, rval=0.
- nparams=6 with beats 1..6 -> all 6 beats accepted, no dispatch, response status=2.
- nparams=0, bfm_done never asserted, TIMEOUT=16 -> response status=3 exactly 16 cycles after dispatch; a late bfm_done afterwards is ignored, and the next call works normally.
- rsp_ready held low for 10 cycles -> rsp fields are stable and hdr_ready stays 0; a same-cycle dispatch+done yields status 0 with the correct rval.
- reset_n pulsed low while in WAIT -> all valids drop immediately and hdr_ready=1 after release; a new call completes OK.
